// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter with a write-side FIFO.
//
// Host logic pushes bytes into a FIFO_DEPTH-entry FIFO. Each byte is sent on
// tx_bit_o as one frame: a start bit (0), DATA_WIDTH data bits LSB first, and
// one stop bit (1). Every bit lasts BAUD_DIV = CLK_FREQ/BAUD_RATE clocks, so
// the line can be looped straight back into uart_rx.
//
// Ports:
//   clk_i     system clock, all logic on the rising edge
//   rst_ni    asynchronous active-low reset
//   tx_en_i   transmit enable; only gates the start of new frames
//   tx_we_i   FIFO write strobe, one entry per cycle while high
//   din_i     byte to enqueue
//   tx_bit_o  serial line, idle high, registered
//   empty_o   FIFO holds no entries
//   full_o    FIFO holds FIFO_DEPTH entries
//   busy_o    frame in progress (START, DATA or STOP)
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_en_i,
  input  logic                  tx_we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  tx_bit_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  wr_en;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Transmit FSM state
  // ---------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [BAUD_W-1:0]     baud_q,    baud_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic                  tx_bit_q,  tx_bit_d;
  logic                  busy_q,    busy_d;

  logic                  baud_last;
  logic                  can_pop;
  logic [DATA_WIDTH-1:0] shifted;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_FULL);
  assign tx_bit_o = tx_bit_q;
  assign busy_o   = busy_q;

  assign baud_last = (baud_q == BAUD_LAST);
  assign can_pop   = tx_en_i && !empty_o;
  assign shifted   = shift_q >> 1;

  // A full FIFO still accepts a write on the cycle it pops, since that pop
  // frees the slot the write lands in.
  assign wr_en = tx_we_i && (!full_o || pop);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // assignment in combinational logic would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next-state. tx_bit_d is computed for the state being entered, so the
  // registered line changes exactly on state and bit boundaries.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_bit_d  = tx_bit_q;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_bit_d = 1'b1;
        if (can_pop) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          baud_d   = '0;
          state_d  = ST_START;
          tx_bit_d = 1'b0;
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
          tx_bit_d  = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d  = ST_STOP;
            tx_bit_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shifted;
            tx_bit_d  = shifted[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: pop on the last stop clock, no idle gap.
          if (can_pop) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            state_d  = ST_START;
            tx_bit_d = 1'b0;
          end else begin
            state_d  = ST_IDLE;
            tx_bit_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tx_bit_d = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: the FIFO array has no reset; the pointers and count define which
  // entries are valid, so clearing the storage itself would buy nothing.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_bit_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_bit_q  <= tx_bit_d;
      busy_q    <= busy_d;
    end
  end

endmodule
